// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - round-robin arbiter driving an active-low 2:4 grant
module rr_decode_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic       gnt_valid,
    output logic [3:0] gnt_n,
    output logic [7:0] busy_cnt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state;
    logic [1:0] pri;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       release_now;

    // Scan from the highest offset down so the lowest offset from pri wins.
    always_comb begin
        winner = pri;
        idx    = pri;
        for (int k = 3; k >= 0; k--) begin
            idx = pri + 2'(k);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign release_now = done || !req[sel] || !en || (busy_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'b00;
            gnt_valid <= 1'b0;
            gnt_n     <= 4'b1111;
            busy_cnt  <= 8'd0;
            pri       <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    busy_cnt <= 8'd0;
                    if (en && (|req)) begin
                        sel       <= winner;
                        gnt_valid <= 1'b1;
                        gnt_n     <= ~(4'b0001 << winner);
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    // Releasing always passes through IDLE, giving break-before-make.
                    if (release_now) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        gnt_n     <= 4'b1111;
                        busy_cnt  <= 8'd0;
                        pri       <= sel + 2'd1;
                    end else begin
                        busy_cnt <= busy_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt_valid <= 1'b0;
                    gnt_n     <= 4'b1111;
                    busy_cnt  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - self-checking bench for rr_decode_arbiter
module tb_rr_decode_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [3:0] req = 4'b1111;
    logic       done = 1'b0;
    logic [1:0] sel;
    logic       gnt_valid;
    logic [3:0] gnt_n;
    logic [7:0] busy_cnt;
    logic [1:0] h1_sel;
    logic       h1_valid;
    logic [3:0] h1_gnt_n;
    logic [7:0] h1_busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       en;
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt_n;
        logic [1:0] sel;
        logic       valid;
        logic [7:0] busy;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] gnt_n;
        logic [1:0] sel;
        logic       valid;
        logic [7:0] busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    rr_decode_arbiter #(.HOLD_MAX(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
        .sel(sel), .gnt_valid(gnt_valid), .gnt_n(gnt_n), .busy_cnt(busy_cnt)
    );

    rr_decode_arbiter #(.HOLD_MAX(1)) u_h1 (
        .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
        .sel(h1_sel), .gnt_valid(h1_valid), .gnt_n(h1_gnt_n), .busy_cnt(h1_busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void add(logic e, logic [3:0] r, logic d,
                                logic [3:0] g, logic [1:0] s, logic v, logic [7:0] b);
        vec_t x;
        x.en = e; x.req = r; x.done = d;
        x.gnt_n = g; x.sel = s; x.valid = v; x.busy = b;
        tbl.push_back(x);
    endfunction

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            logic [3:0] inv;
            e = sb.pop_front();
            check($sformatf("row%0d_gnt_n", e.idx), 8'(gnt_n), 8'(e.gnt_n));
            check($sformatf("row%0d_sel", e.idx), 8'(sel), 8'(e.sel));
            check($sformatf("row%0d_valid", e.idx), 8'(gnt_valid), 8'(e.valid));
            check($sformatf("row%0d_busy", e.idx), busy_cnt, e.busy);
            inv = gnt_valid ? ~(4'b0001 << sel) : 4'b1111;
            check($sformatf("row%0d_onehot", e.idx), 8'(gnt_n), 8'(inv));
        end
    end

    initial begin
        exp_t e;
        // rotation with done in each grant's first cycle
        add(1, 4'b1111, 0, 4'b1110, 0, 1, 0);
        add(1, 4'b1111, 1, 4'b1111, 0, 0, 0);
        add(1, 4'b1111, 0, 4'b1101, 1, 1, 0);
        add(1, 4'b1111, 1, 4'b1111, 1, 0, 0);
        add(1, 4'b1111, 0, 4'b1011, 2, 1, 0);
        add(1, 4'b1111, 1, 4'b1111, 2, 0, 0);
        add(1, 4'b1111, 0, 4'b0111, 3, 1, 0);
        add(1, 4'b1111, 1, 4'b1111, 3, 0, 0);
        add(1, 4'b1111, 0, 4'b1110, 0, 1, 0);
        add(1, 4'b1111, 1, 4'b1111, 0, 0, 0);
        // skip/wrap
        add(1, 4'b0100, 0, 4'b1011, 2, 1, 0);
        add(1, 4'b0100, 1, 4'b1111, 2, 0, 0);
        add(1, 4'b1001, 0, 4'b0111, 3, 1, 0);
        add(1, 4'b1001, 1, 4'b1111, 3, 0, 0);
        add(1, 4'b1001, 0, 4'b1110, 0, 1, 0);
        // owner drops its request
        add(1, 4'b0000, 0, 4'b1111, 0, 0, 0);
        add(1, 4'b0000, 0, 4'b1111, 0, 0, 0);
        // timeout at HOLD_MAX=4
        add(1, 4'b0010, 0, 4'b1101, 1, 1, 0);
        add(1, 4'b0010, 0, 4'b1101, 1, 1, 1);
        add(1, 4'b0010, 0, 4'b1101, 1, 1, 2);
        add(1, 4'b0010, 0, 4'b1101, 1, 1, 3);
        add(1, 4'b0010, 0, 4'b1111, 1, 0, 0);
        add(1, 4'b0010, 0, 4'b1101, 1, 1, 0);
        // enable drop blocks grants
        add(0, 4'b1111, 0, 4'b1111, 1, 0, 0);
        add(0, 4'b1111, 0, 4'b1111, 1, 0, 0);
        add(0, 4'b1111, 0, 4'b1111, 1, 0, 0);
        // leave pri=3 with requester 2 owning the grant
        add(1, 4'b0100, 0, 4'b1011, 2, 1, 0);
        add(1, 4'b0100, 1, 4'b1111, 2, 0, 0);
        add(1, 4'b0100, 0, 4'b1011, 2, 1, 0);
        add(1, 4'b0100, 0, 4'b1011, 2, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt_n", 8'(gnt_n), 8'hf);
        check("reset_valid", 8'(gnt_valid), 8'h0);
        check("reset_sel", 8'(sel), 8'h0);
        check("reset_busy", busy_cnt, 8'h0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) @(negedge clk);
            en = tbl[i].en; req = tbl[i].req; done = tbl[i].done;
            e.idx = i + 1; e.gnt_n = tbl[i].gnt_n; e.sel = tbl[i].sel;
            e.valid = tbl[i].valid; e.busy = tbl[i].busy;
            sb.push_back(e);
        end

        // asynchronous reset between edges while gnt_n=1011
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_gnt_n", 8'(gnt_n), 8'hf);
        check("async_valid", 8'(gnt_valid), 8'h0);
        check("async_sel", 8'(sel), 8'h0);
        check("async_busy", busy_cnt, 8'h0);

        @(negedge clk);
        rst = 1'b0; en = 1'b1; req = 4'b1100; done = 1'b0;
        e.idx = 99; e.gnt_n = 4'b1011; e.sel = 2; e.valid = 1; e.busy = 0;
        sb.push_back(e);
        @(negedge clk);

        // HOLD_MAX=1: grants alternate with single idle cycles
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("h1_valid%0d", i), 8'(h1_valid), (i % 2 == 0) ? 8'h1 : 8'h0);
            check($sformatf("h1_gnt_n%0d", i), 8'(h1_gnt_n), (i % 2 == 0) ? 8'he : 8'hf);
        end

        repeat (2) @(posedge clk);
        #2;
        check("sb_drained", 8'(sb.size()), 8'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
